// File: rtl/dmi_pipe_if.sv
// DMI handshake bundle between the DTM-side master, the pipe buffer and the
// Debug Module. The buffer uses the slave view; its environment uses master.
interface dmi_pipe_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [ADDR_W+2+DATA_W-1:0] host_req;
  logic                       host_req_valid;
  logic                       host_req_ready;
  logic [DATA_W+2-1:0]        host_resp;
  logic                       host_resp_valid;
  logic                       host_resp_ready;
  logic [ADDR_W+2+DATA_W-1:0] dm_req;
  logic                       dm_req_valid;
  logic                       dm_req_ready;
  logic [DATA_W+2-1:0]        dm_resp;
  logic                       dm_resp_valid;
  logic                       dm_resp_ready;

  modport slave (
    input  host_req, host_req_valid, host_resp_ready,
    input  dm_req_ready, dm_resp, dm_resp_valid,
    output host_req_ready, host_resp, host_resp_valid,
    output dm_req, dm_req_valid, dm_resp_ready
  );

  modport master (
    output host_req, host_req_valid, host_resp_ready,
    output dm_req_ready, dm_resp, dm_resp_valid,
    input  host_req_ready, host_resp, host_resp_valid,
    input  dm_req, dm_req_valid, dm_resp_ready
  );
endinterface

// File: rtl/dmi_pipe_buffer.sv
// DMI request/response buffer: request FIFO toward the DM, response FIFO
// toward the host, an outstanding-request limiter and a flush that arms
// dropping of responses still in flight from the DM.
// Optional feature macro: DMI_PIPE_TIMEOUT_EN (injects an error response,
// resp=2, when the DM stays silent for TIMEOUT_CYC cycles).
module dmi_pipe_buffer #(
  parameter int ADDR_W          = 7,
  parameter int DATA_W          = 32,
  parameter int REQ_DEPTH       = 4,
  parameter int RESP_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYC     = 1024,
  localparam int OCW            = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  output logic           clear_o,
  dmi_pipe_if.slave      dmi,
  output logic [OCW-1:0] out_cnt_o,
  output logic           timeout_o
);
  localparam int REQ_W  = ADDR_W + 2 + DATA_W;
  localparam int RESP_W = DATA_W + 2;
  localparam int RQ_AW  = $clog2(REQ_DEPTH);
  localparam int RS_AW  = $clog2(RESP_DEPTH);
  localparam int RQ_CW  = RQ_AW + 1;
  localparam int RS_CW  = RS_AW + 1;
  localparam logic [OCW-1:0] MAX_OC = OCW'(MAX_OUTSTANDING);

  logic [REQ_W-1:0]  req_mem_q  [REQ_DEPTH];
  logic [RESP_W-1:0] resp_mem_q [RESP_DEPTH];
  logic [RQ_AW-1:0]  req_wp_q, req_wp_d, req_rp_q, req_rp_d;
  logic [RQ_CW-1:0]  req_cnt_q, req_cnt_d;
  logic [RS_AW-1:0]  resp_wp_q, resp_wp_d, resp_rp_q, resp_rp_d;
  logic [RS_CW-1:0]  resp_cnt_q, resp_cnt_d;
  logic [OCW-1:0]    out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
  logic              clear_q;

  logic req_full, req_empty, resp_full, resp_empty;
  logic req_push, req_pop, resp_push, resp_pop;
  logic dm_hs, accept, drop, inject, dec_out;
  logic [RESP_W-1:0] resp_wdata;
  logic [OCW:0]      drop_sum;

  assign req_full   = (req_cnt_q == RQ_CW'(REQ_DEPTH));
  assign req_empty  = (req_cnt_q == '0);
  assign resp_full  = (resp_cnt_q == RS_CW'(RESP_DEPTH));
  assign resp_empty = (resp_cnt_q == '0);

  // Flush blocks new host requests and new issues in the cycle it is seen.
  assign dmi.host_req_ready  = !req_full && !clear_i;
  assign dmi.dm_req_valid    = !req_empty && (out_cnt_q < MAX_OC) && !clear_i;
  assign dmi.dm_resp_ready   = (drop_cnt_q != '0) || !resp_full;
  assign dmi.host_resp_valid = !resp_empty;
  assign dmi.dm_req          = req_mem_q[req_rp_q];
  assign dmi.host_resp       = resp_mem_q[resp_rp_q];

  assign req_push = dmi.host_req_valid && dmi.host_req_ready;
  assign req_pop  = dmi.dm_req_valid && dmi.dm_req_ready;
  assign dm_hs    = dmi.dm_resp_valid && dmi.dm_resp_ready && !clear_i;
  assign accept   = dm_hs && (drop_cnt_q == '0);
  assign drop     = dm_hs && (drop_cnt_q != '0);
  assign resp_pop = dmi.host_resp_valid && dmi.host_resp_ready && !clear_i;

`ifdef DMI_PIPE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          timer_hit;

  assign timer_hit = (timer_q == TW'(TIMEOUT_CYC));
  // A real DM response in the same cycle always beats the injected error.
  assign inject = !clear_i && (out_cnt_q != '0) && timer_hit && !resp_full && !dm_hs;

  // Timer runs only while something is outstanding; held at the limit while
  // the response FIFO has no room for the injected error.
  always_comb begin
    timer_d = timer_q + TW'(1);
    if (clear_i || (out_cnt_q == '0) || dm_hs || inject) timer_d = '0;
    else if (timer_hit)                                  timer_d = timer_q;
  end

  // Timer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign inject = 1'b0;
`endif

  assign timeout_o  = inject;
  assign resp_push  = accept || inject;
  assign resp_wdata = inject ? {{DATA_W{1'b0}}, 2'd2} : dmi.dm_resp;
  assign dec_out    = (accept && (out_cnt_q != '0)) || inject;
  assign drop_sum   = {1'b0, drop_cnt_q} + {1'b0, out_cnt_q};

  // Next-state for FIFO pointers/counts and the outstanding/drop counters.
  always_comb begin
    req_wp_d   = req_wp_q + RQ_AW'(req_push);
    req_rp_d   = req_rp_q + RQ_AW'(req_pop);
    req_cnt_d  = req_cnt_q + RQ_CW'(req_push) - RQ_CW'(req_pop);
    resp_wp_d  = resp_wp_q + RS_AW'(resp_push);
    resp_rp_d  = resp_rp_q + RS_AW'(resp_pop);
    resp_cnt_d = resp_cnt_q + RS_CW'(resp_push) - RS_CW'(resp_pop);
    out_cnt_d  = out_cnt_q + OCW'(req_pop) - OCW'(dec_out);
    drop_cnt_d = drop_cnt_q;
    if (drop)                             drop_cnt_d = drop_cnt_q - OCW'(1);
    else if (inject && drop_cnt_q < MAX_OC) drop_cnt_d = drop_cnt_q + OCW'(1);
    if (clear_i) begin
      // Everything the DM still owes us becomes a response to discard.
      req_wp_d   = '0;
      req_rp_d   = '0;
      req_cnt_d  = '0;
      resp_wp_d  = '0;
      resp_rp_d  = '0;
      resp_cnt_d = '0;
      out_cnt_d  = '0;
      drop_cnt_d = (drop_sum > {1'b0, MAX_OC}) ? MAX_OC : drop_sum[OCW-1:0];
    end
  end

  // Control state registers; reset wins over flush and arms no drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_wp_q   <= '0;
      req_rp_q   <= '0;
      req_cnt_q  <= '0;
      resp_wp_q  <= '0;
      resp_rp_q  <= '0;
      resp_cnt_q <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      clear_q    <= 1'b0;
    end else begin
      req_wp_q   <= req_wp_d;
      req_rp_q   <= req_rp_d;
      req_cnt_q  <= req_cnt_d;
      resp_wp_q  <= resp_wp_d;
      resp_rp_q  <= resp_rp_d;
      resp_cnt_q <= resp_cnt_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      clear_q    <= clear_i;
    end
  end

  // FIFO storage; contents need no reset since the counts gate visibility.
  always_ff @(posedge clk_i) begin
    if (req_push)  req_mem_q[req_wp_q]   <= dmi.host_req;
    if (resp_push) resp_mem_q[resp_wp_q] <= resp_wdata;
  end

  assign clear_o   = clear_q;
  assign out_cnt_o = out_cnt_q;
endmodule
